// File: rtl/tank_pump_ctrl_if.sv
// tank_pump_ctrl_if -- sensor/operator inputs and status outputs of the tank
// pump controller, bundled so the controller and its driver share one handle.
//   sens_low  : raw low-level sensor, 1 = water above the low mark
//   sens_high : raw high-level sensor, 1 = water above the high mark
//   ack       : operator fault acknowledge (level)
//   pump      : pump drive
//   full      : tank-full indicator
//   fault     : alarm
//   state     : controller state, IDLE=00 FILL=01 FULL=10 FAULT=11
// master drives the sensors and ack; slave (the controller) drives the status.
`timescale 1ns/1ps
interface tank_pump_ctrl_if;
    logic       sens_low;
    logic       sens_high;
    logic       ack;
    logic       pump;
    logic       full;
    logic       fault;
    logic [1:0] state;

    modport master (
        output sens_low, sens_high, ack,
        input  pump, full, fault, state
    );

    modport slave (
        input  sens_low, sens_high, ack,
        output pump, full, fault, state
    );
endinterface

// File: rtl/tank_pump_ctrl.sv
// tank_pump_ctrl -- fills a tank between a low and a high level mark.
// Both raw sensors are debounced; a Moore FSM runs the pump, enforces a minimum
// pump-off time, times out a fill that never reaches the top, and latches an
// alarm on an impossible sensor pair (high wet, low dry) until acknowledged.
//   clk_2 : clock, all state updates on its rising edge
//   reset : asynchronous, active-high
//   bus   : tank_pump_ctrl_if.slave (sens_low, sens_high, ack in;
//           pump, full, fault, state out)
`timescale 1ns/1ps
module tank_pump_ctrl #(
    parameter int unsigned DEB_CYCLES = 3,
    parameter int unsigned MIN_OFF    = 4,
    parameter int unsigned MAX_FILL   = 20
) (
    input  logic            clk_2,
    input  logic            reset,
    tank_pump_ctrl_if.slave bus
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned OW = $clog2(MIN_OFF + 1);
    localparam int unsigned FW = $clog2(MAX_FILL + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [OW-1:0] OFF_SAT   = OW'(MIN_OFF);
    localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL - 1);
    localparam logic [FW-1:0] FILL_SAT  = FW'(MAX_FILL);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        FULL  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          lo_s, hi_s;
    logic [DW-1:0] lo_cnt, hi_cnt;
    logic [OW-1:0] off_cnt;
    logic [FW-1:0] fill_cnt;
    logic          incons;

    // Next {stable, counter} for one debouncer: the stable copy follows raw
    // only after DEB_CYCLES consecutive differing samples.
    function automatic logic [DW:0] deb_next(input logic raw, input logic stab,
                                             input logic [DW-1:0] cnt);
        logic [DW:0] r;
        if (raw == stab) begin
            r[DW]     = stab;
            r[DW-1:0] = '0;
        end else if (cnt == DEB_LAST) begin
            r[DW]     = raw;
            r[DW-1:0] = '0;
        end else begin
            r[DW]     = stab;
            r[DW-1:0] = cnt + 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            lo_s   <= 1'b0;
            lo_cnt <= '0;
            hi_s   <= 1'b0;
            hi_cnt <= '0;
        end else begin
            {lo_s, lo_cnt} <= deb_next(bus.sens_low,  lo_s, lo_cnt);
            {hi_s, hi_cnt} <= deb_next(bus.sens_high, hi_s, hi_cnt);
        end
    end

    // High wet while low is dry cannot happen with working sensors.
    assign incons = hi_s & ~lo_s;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (incons)                         state_d = FAULT;
                else if (!lo_s && off_cnt == OFF_SAT) state_d = FILL;
                else if (lo_s && hi_s)              state_d = FULL;
            end
            FILL: begin
                if (incons)                         state_d = FAULT;
                else if (lo_s && hi_s)              state_d = FULL;
                else if (fill_cnt == FILL_LAST)     state_d = FAULT;
            end
            FULL: begin
                if (incons)                         state_d = FAULT;
                else if (!lo_s)                     state_d = IDLE;
            end
            FAULT: begin
                if (bus.ack && !incons)             state_d = IDLE;
            end
            default:                                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Both timers restart on entry to their state and saturate, so they
    // never wrap however long the state is held.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            off_cnt  <= '0;
            fill_cnt <= '0;
        end else begin
            if (state_d == IDLE && state_q != IDLE)
                off_cnt <= '0;
            else if (state_q == IDLE && off_cnt != OFF_SAT)
                off_cnt <= off_cnt + 1'b1;

            if (state_d == FILL && state_q != FILL)
                fill_cnt <= '0;
            else if (state_q == FILL && fill_cnt != FILL_SAT)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign bus.pump  = (state_q == FILL);
    assign bus.full  = (state_q == FULL);
    assign bus.fault = (state_q == FAULT);
    assign bus.state = state_q;

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// tb_tank_pump_ctrl -- directed scenarios with literal expectations followed by
// randomized sensor/ack/reset stimulus, all compared against a behavioural
// model of the controller on every falling clock edge.
`timescale 1ns/1ps
module tb_tank_pump_ctrl;

    localparam int DEB   = 3;
    localparam int MOFF  = 4;
    localparam int MFILL = 20;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_FULL  = 2;
    localparam int M_FAULT = 3;

    logic clk_2;
    logic reset;
    tank_pump_ctrl_if bus();

    tank_pump_ctrl #(
        .DEB_CYCLES (DEB),
        .MIN_OFF    (MOFF),
        .MAX_FILL   (MFILL)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State plus "edges spent in this state"; each debounced level is derived
    // from the history of the last DEB raw samples.
    int m_state;
    int m_since;
    bit m_lo, m_hi;
    bit lo_h[$];
    bit hi_h[$];
    int m_nxt;
    bit m_inc;

    function automatic bit settles(input bit h[$], input bit s);
        int d = 0;
        foreach (h[i]) if (h[i] != s) d++;
        return (h.size() == DEB) && (d == DEB);
    endfunction

    always @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE;
            m_since = 0;
            m_lo    = 1'b0;
            m_hi    = 1'b0;
            lo_h.delete();
            hi_h.delete();
        end else begin
            m_inc = m_hi && !m_lo;
            m_nxt = m_state;
            case (m_state)
                M_IDLE:  m_nxt = m_inc ? M_FAULT :
                                 (!m_lo && m_since >= MOFF) ? M_FILL :
                                 (m_lo && m_hi) ? M_FULL : M_IDLE;
                M_FILL:  m_nxt = m_inc ? M_FAULT :
                                 (m_lo && m_hi) ? M_FULL :
                                 (m_since + 1 >= MFILL) ? M_FAULT : M_FILL;
                M_FULL:  m_nxt = m_inc ? M_FAULT : (!m_lo ? M_IDLE : M_FULL);
                default: m_nxt = (bus.ack && !m_inc) ? M_IDLE : M_FAULT;
            endcase
            m_since = (m_nxt != m_state) ? 0 : m_since + 1;
            m_state = m_nxt;

            lo_h.push_back(bit'(bus.sens_low));
            if (lo_h.size() > DEB) void'(lo_h.pop_front());
            hi_h.push_back(bit'(bus.sens_high));
            if (hi_h.size() > DEB) void'(hi_h.pop_front());
            if (settles(lo_h, m_lo)) m_lo = ~m_lo;
            if (settles(hi_h, m_hi)) m_hi = ~m_hi;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_2) begin
        if (run_cmp && reset === 1'b0) begin
            chk("state", int'(bus.state), m_state);
            chk("pump",  int'(bus.pump),  int'(m_state == M_FILL));
            chk("full",  int'(bus.full),  int'(m_state == M_FULL));
            chk("fault", int'(bus.fault), int'(m_state == M_FAULT));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #2;
    endtask

    task automatic wait_state(input int s, input int max_ticks, input string nm);
        int k = 0;
        while (int'(bus.state) != s && k < max_ticks) begin
            tick(1);
            k++;
        end
        chk(nm, int'(bus.state), s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat;
        int len;
        reset         = 1'b1;
        bus.sens_low  = 1'b0;
        bus.sens_high = 1'b0;
        bus.ack       = 1'b0;
        tick(2);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pump",  int'(bus.pump),  0);
        chk("rst_full",  int'(bus.full),  0);
        chk("rst_fault", int'(bus.fault), 0);
        reset   = 1'b0;
        run_cmp = 1'b1;

        // Minimum off time after reset, then fill.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("boot_idle", int'(bus.state), 0);
        end
        tick(1);
        chk("boot_fill_state", int'(bus.state), 1);
        chk("boot_fill_pump",  int'(bus.pump),  1);

        // Reach the top: debounce latency then FULL.
        bus.sens_low  = 1'b1;
        bus.sens_high = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("fill_hold_pump", int'(bus.pump), 1);
        end
        tick(1);
        chk("full_pump",  int'(bus.pump),  0);
        chk("full_full",  int'(bus.full),  1);
        chk("full_state", int'(bus.state), 2);

        // Hysteresis: high mark drops, short low glitch, then a real drop.
        bus.sens_high = 1'b0;
        tick(4);
        chk("full_hi_drop", int'(bus.state), 2);
        bus.sens_low = 1'b0;
        tick(2);
        bus.sens_low = 1'b1;
        tick(4);
        chk("full_glitch", int'(bus.state), 2);
        bus.sens_low = 1'b0;
        tick(3);
        chk("full_deb", int'(bus.state), 2);
        tick(1);
        chk("full_to_idle", int'(bus.state), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("refill_wait", int'(bus.state), 0);
        end
        tick(1);
        chk("refill", int'(bus.state), 1);

        // Fill timeout with dry sensors.
        for (int i = 0; i < MFILL - 1; i++) begin
            tick(1);
            chk("fill_run", int'(bus.state), 1);
        end
        tick(1);
        chk("timeout_fault", int'(bus.fault), 1);
        chk("timeout_pump",  int'(bus.pump),  0);
        bus.ack = 1'b1;
        tick(1);
        chk("timeout_ack", int'(bus.state), 0);
        bus.ack = 1'b0;

        // Inconsistent sensors from FULL; ack ignored while it persists.
        bus.sens_low  = 1'b1;
        bus.sens_high = 1'b1;
        wait_state(2, 10, "reach_full");
        bus.sens_low = 1'b0;
        tick(3);
        chk("incons_deb", int'(bus.state), 2);
        tick(1);
        chk("incons_fault", int'(bus.state), 3);
        bus.ack = 1'b1;
        tick(2);
        chk("ack_ignored", int'(bus.state), 3);
        bus.ack       = 1'b0;
        bus.sens_high = 1'b0;
        tick(4);
        chk("fault_holds", int'(bus.state), 3);
        bus.ack = 1'b1;
        tick(1);
        chk("fault_ack", int'(bus.state), 0);
        bus.ack = 1'b0;

        // Asynchronous reset mid-fill.
        wait_state(1, 8, "reach_fill");
        tick(3);
        #1 reset = 1'b1;
        #1;
        chk("async_pump",  int'(bus.pump),  0);
        chk("async_state", int'(bus.state), 0);
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("post_rst_idle", int'(bus.state), 0);
        end
        tick(1);
        chk("post_rst_fill", int'(bus.state), 1);

        // Randomized segments of held sensor pairs, glitches, acks and resets.
        for (int seg = 0; seg < 250; seg++) begin
            pat = $urandom_range(0, 9);
            bus.sens_low  = (pat >= 4 && pat <= 8);
            bus.sens_high = (pat >= 4 && pat <= 6) || pat == 9;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2)
                                              : $urandom_range(3, 30);
            for (int k = 0; k < len; k++) begin
                bus.ack = ($urandom_range(0, 5) == 0);
                tick(1);
                if ($urandom_range(0, 399) == 0) begin
                    #1 reset = 1'b1;
                    #1 reset = 1'b0;
                end
            end
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
